// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// Defining MULT_UNSIGNED_EN adds one extension bit so that multu is exact.
package mult_pkg;

   typedef enum logic [1:0] {
      MULT_IDLE = 2'd0,
      MULT_RUN  = 2'd1,
      MULT_DONE = 2'd2
   } mult_state_t;

   localparam int MULT_WIDTH = 32;

`ifdef MULT_UNSIGNED_EN
   localparam int MULT_EXT = 1;
`else
   localparam int MULT_EXT = 0;
`endif

   function automatic int mult_iter(input int width);
      return width + MULT_EXT;
   endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth step: conditional add/sub of M into the upper half of P,
// then an arithmetic right shift of the whole P register by one bit.
module mult_booth_step #(
   parameter int UW = 34,
   parameter int LW = 33
) (
   input  logic [UW+LW:0] p,
   input  logic [UW-1:0]  m,
   input  logic [1:0]     pair,
   output logic [UW+LW:0] p_next
);

   logic [UW-1:0] upper;
   logic [UW-1:0] sum;

   assign upper = p[UW+LW:LW+1];

   always_comb begin
      case (pair)
         2'b01:   sum = upper + m;
         2'b10:   sum = upper - m;
         default: sum = upper;
      endcase
   end

   // The old Q-1 bit falls off the bottom; the upper sign bit is replicated.
   assign p_next = $signed({sum, p[LW:0]}) >>> 1;

endmodule

// File: rtl/mult.sv
// Sequential Booth multiplier producing {hi_mult, lo_mult} after ITER steps.
// MULT_UNSIGNED_EN adds the unsigned_op port and a 33-step unsigned-capable mode.
module mult
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
`ifdef MULT_UNSIGNED_EN
   input  logic             unsigned_op,
`endif
   output logic [WIDTH-1:0] hi_mult,
   output logic [WIDTH-1:0] lo_mult,
   output logic             busy,
   output logic             done,
   output mult_state_t      state
);

   // Handshake: start is sampled only in IDLE; busy covers the ITER steps;
   // done pulses once and HI/LO stay valid until the next completion.
   localparam int LW   = WIDTH + MULT_EXT;
   localparam int UW   = LW + 1;
   localparam int PW   = UW + LW + 1;
   localparam int ITER = mult_iter(WIDTH);
   localparam int CW   = $clog2(ITER + 1);

   logic [LW-1:0] ext_a;
   logic [LW-1:0] ext_b;
   logic [UW-1:0] m;
   logic [PW-1:0] p;
   logic [PW-1:0] p_next;
   logic [CW-1:0] count;

`ifdef MULT_UNSIGNED_EN
   assign ext_a = {~unsigned_op & multiplicand[WIDTH-1], multiplicand};
   assign ext_b = {~unsigned_op & multiplier[WIDTH-1], multiplier};
`else
   assign ext_a = multiplicand;
   assign ext_b = multiplier;
`endif

   mult_booth_step #(
      .UW(UW),
      .LW(LW)
   ) u_step (
      .p      (p),
      .m      (m),
      .pair   (p[1:0]),
      .p_next (p_next)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= MULT_IDLE;
         count   <= '0;
         m       <= '0;
         p       <= '0;
         hi_mult <= '0;
         lo_mult <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            MULT_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m     <= {ext_a[LW-1], ext_a};
                  p     <= {{UW{1'b0}}, ext_b, 1'b0};
                  count <= '0;
                  busy  <= 1'b1;
                  state <= MULT_RUN;
               end
            end
            MULT_RUN: begin
               p     <= p_next;
               count <= count + 1'b1;
               if (count == CW'(ITER - 1)) begin
                  {hi_mult, lo_mult} <= p_next[2*WIDTH:1];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= MULT_DONE;
               end
            end
            MULT_DONE: begin
               done  <= 1'b0;
               state <= MULT_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= MULT_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult.sv
// Directed bench for mult: an arithmetic product model feeds an expected queue
// that a per-cycle compare process checks against HI/LO.
module tb_mult;
   import mult_pkg::*;

`ifdef MULT_UNSIGNED_EN
   localparam int ITER = 33;
`else
   localparam int ITER = 32;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] multiplicand = '0;
   logic [31:0] multiplier = '0;
`ifdef MULT_UNSIGNED_EN
   logic        unsigned_op = 1'b0;
`endif
   logic [31:0] hi_mult;
   logic [31:0] lo_mult;
   logic        busy;
   logic        done;
   mult_state_t state;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;
   logic [63:0] exp_q[$];
   logic [63:0] cur_exp = '0;

   mult dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
`ifdef MULT_UNSIGNED_EN
      .unsigned_op  (unsigned_op),
`endif
      .hi_mult      (hi_mult),
      .lo_mult      (lo_mult),
      .busy         (busy),
      .done         (done),
      .state        (state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%016h expected=0x%016h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit u);
      longint sa;
      longint sb;
      if (u) return {32'd0, a} * {32'd0, b};
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
   endfunction

   // Model state: a reset edge flushes pending results and zeroes the expected HI/LO.
   always @(posedge clock) begin
      if (reset) begin
         exp_q.delete();
         cur_exp = '0;
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done hi=0x%08h lo=0x%08h", hi_mult, lo_mult);
            end else begin
               cur_exp = exp_q.pop_front();
            end
         end
         check("hilo_track", {hi_mult, lo_mult}, cur_exp);
      end
   end

   // mode 1: operands change mid-run; mode 2: start pulses at step 5 and in DONE.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit u, input int mode);
      int n;
      bit seen;
      @(negedge clock);
      multiplicand = a;
      multiplier   = b;
`ifdef MULT_UNSIGNED_EN
      unsigned_op  = u;
`endif
      start = 1'b1;
      @(posedge clock);
      exp_q.push_back(model(a, b, u));
      @(negedge clock);
      start = 1'b0;
      check("busy_after_start", {63'd0, busy}, 64'd1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < ITER + 4) begin
         if (mode == 1 && n == 3) begin
            multiplicand = 32'h1234_5678;
            multiplier   = 32'h8765_4321;
         end
         if (mode == 2 && n == 4) begin
            multiplicand = 32'd2;
            multiplier   = 32'd2;
            start = 1'b1;
         end
         if (mode == 2 && n == 5) start = 1'b0;
         @(posedge clock);
         n++;
         @(negedge clock);
         if (done) seen = 1'b1;
      end
      check("latency", 64'(n), 64'(ITER));
      check("busy_at_done", {63'd0, busy}, 64'd0);
      if (mode == 2) begin
         multiplicand = 32'd2;
         multiplier   = 32'd2;
         start = 1'b1;
      end
      @(negedge clock);
      start = 1'b0;
      check("done_one_cycle", {63'd0, done}, 64'd0);
      check("idle_after_done", 64'(state), 64'(MULT_IDLE));
   endtask

   logic [31:0] va[7] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                          32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFE};
   logic [31:0] vb[7] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                          32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF};
   logic [63:0] vp[7] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                          64'h0000_0000_0000_0001, 64'h3FFF_FFFF_0000_0001,
                          64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_0000,
                          64'hFFFF_FFFF_0000_0002};

   initial begin
      // Reset held for two edges.
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_hilo", {hi_mult, lo_mult}, 64'd0);
      check("reset_busy_done", {62'd0, busy, done}, 64'd0);
      check("reset_state", 64'(state), 64'(MULT_IDLE));
      cmp_en = 1'b1;
      reset = 1'b0;

      // Pin the model to hand-computed products.
      check("pin_5x6", model(32'd5, 32'd6, 1'b0), 64'd30);
      check("pin_unsigned_ones", model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1), 64'hFFFF_FFFE_0000_0001);

      for (int i = 0; i < 7; i++) begin
         check("pin_vector", model(va[i], vb[i], 1'b0), vp[i]);
         run_op(va[i], vb[i], 1'b0, 0);
         check("vector_result", {hi_mult, lo_mult}, vp[i]);
      end

`ifdef MULT_UNSIGNED_EN
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
      check("multu_ones", {hi_mult, lo_mult}, 64'hFFFF_FFFE_0000_0001);
`endif

      // Abort with reset at step 10 after a non-zero result is on the outputs.
      @(negedge clock);
      multiplicand = 32'd5;
      multiplier   = 32'd6;
      start = 1'b1;
      @(posedge clock);
      exp_q.push_back(model(32'd5, 32'd6, 1'b0));
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("abort_state", 64'(state), 64'(MULT_IDLE));
      check("abort_busy_done", {62'd0, busy, done}, 64'd0);
      check("abort_hilo", {hi_mult, lo_mult}, 64'd0);
      reset = 1'b0;
      repeat (ITER + 3) @(negedge clock);
      check("abort_no_busy", {63'd0, busy}, 64'd0);

      // Start pulses during RUN and DONE are ignored.
      run_op(32'd5, 32'd6, 1'b0, 2);
      check("ignored_starts_result", {hi_mult, lo_mult}, 64'd30);
      repeat (3) @(negedge clock);
      check("ignored_starts_idle", {62'd0, busy, done}, 64'd0);

      // Operand changes after sampling, then back-to-back op; outputs hold 30 meanwhile.
      run_op(32'd5, 32'd6, 1'b0, 1);
      check("operand_change_result", {hi_mult, lo_mult}, 64'd30);
      run_op(32'd2, 32'd2, 1'b0, 0);
      check("second_result", {hi_mult, lo_mult}, 64'd4);

      repeat (2) @(negedge clock);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

endmodule
